// File: rtl/reg_readback.sv
// Register-file readback sweeper: reads every register in turn and streams each one out as a valid/ready beat.
// Optional REG_READBACK_CHECKSUM_EN adds a trailing XOR-checksum beat after the register beats.
module reg_readback #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    output logic [A-1:0] RaddrOut,
    input  logic [W-1:0] RdataIn,
    output logic [W-1:0] OutData,
    output logic [A-1:0] OutAddr,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         OutLast,
    output logic         Busy,
    output logic         Done
);

    localparam logic [A-1:0] LAST_ADDR = A'(2**A - 1);

`ifdef REG_READBACK_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_FINISH,
        ST_CKSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_FINISH
    } state_t;
`endif

    state_t       state;
    state_t       state_next;
    logic [A-1:0] cnt;
    logic [A-1:0] cnt_next;
    logic [W-1:0] data_next;
    logic [A-1:0] addr_next;
    logic         last_next;
    logic         valid_next;
    logic         busy_next;
    logic         done_next;
    logic         handshake;
`ifdef REG_READBACK_CHECKSUM_EN
    logic [W-1:0] acc;
    logic [W-1:0] acc_next;
`endif

    assign RaddrOut  = cnt;
    assign handshake = OutValid & OutReady;

    // State register and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            OutData  <= '0;
            OutAddr  <= '0;
            OutLast  <= 1'b0;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
`ifdef REG_READBACK_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            OutData  <= data_next;
            OutAddr  <= addr_next;
            OutLast  <= last_next;
            OutValid <= valid_next;
            Busy     <= busy_next;
            Done     <= done_next;
`ifdef REG_READBACK_CHECKSUM_EN
            acc      <= acc_next;
`endif
        end
    end

    // Next-state and next-output logic; Abort wins over any handshake outside IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = OutData;
        addr_next  = OutAddr;
        last_next  = OutLast;
`ifdef REG_READBACK_CHECKSUM_EN
        acc_next   = acc;
`endif
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_FETCH;
                    cnt_next   = '0;
`ifdef REG_READBACK_CHECKSUM_EN
                    acc_next   = '0;
`endif
                end
            end
            ST_FETCH: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_SEND;
                    data_next  = RdataIn;
                    addr_next  = cnt;
`ifdef REG_READBACK_CHECKSUM_EN
                    last_next  = 1'b0;
                    acc_next   = acc ^ RdataIn;
`else
                    last_next  = (cnt == LAST_ADDR);
`endif
                end
            end
            ST_SEND: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (handshake) begin
                    if (cnt == LAST_ADDR) begin
`ifdef REG_READBACK_CHECKSUM_EN
                        state_next = ST_CKSUM;
                        data_next  = acc;
                        addr_next  = '0;
                        last_next  = 1'b1;
`else
                        state_next = ST_FINISH;
`endif
                    end else begin
                        state_next = ST_FETCH;
                        cnt_next   = cnt + A'(1);
                    end
                end
            end
`ifdef REG_READBACK_CHECKSUM_EN
            ST_CKSUM: begin
                if (Abort) begin
                    state_next = ST_IDLE;
                end else if (handshake) begin
                    state_next = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef REG_READBACK_CHECKSUM_EN
        valid_next = (state_next == ST_SEND) || (state_next == ST_CKSUM);
`else
        valid_next = (state_next == ST_SEND);
`endif
        busy_next  = (state_next != ST_IDLE);
        done_next  = (state_next == ST_FINISH);
    end

endmodule

// File: tb/tb_reg_readback.sv
// Scoreboard bench for reg_readback: stimulus pushes expected beats, a monitor pops them on each accepted beat.
module tb_reg_readback;

    localparam int unsigned W  = 8;
    localparam int unsigned A  = 2;
    localparam int unsigned NR = 4;
`ifdef REG_READBACK_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    logic         Clk = 1'b0;
    logic         Reset, Start, Abort, OutReady;
    logic [A-1:0] RaddrOut, OutAddr;
    logic [W-1:0] RdataIn, OutData;
    logic         OutValid, OutLast, Busy, Done;

    logic [W-1:0] regs [NR];

    typedef struct packed {
        logic [W-1:0] d;
        logic [A-1:0] a;
        logic         l;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int done_exp = 0;

    reg_readback #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .RaddrOut(RaddrOut), .RdataIn(RdataIn),
        .OutData(OutData), .OutAddr(OutAddr), .OutValid(OutValid),
        .OutReady(OutReady), .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Register file model: combinational read.
    assign RdataIn = regs[RaddrOut];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected stream of a whole sweep over the current register contents.
    task automatic push_model();
        beat_t b;
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i < int'(NR); i++) begin
            b.d = regs[i];
            b.a = A'(i);
            b.l = (i == int'(NR) - 1) && (CKS == 0);
            exp_q.push_back(b);
            x = x ^ regs[i];
        end
        if (CKS != 0) begin
            b.d = x;
            b.a = '0;
            b.l = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic start_sweep(input logic with_abort);
        push_model();
        Start = 1'b1;
        Abort = with_abort;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic wait_done(input logic rand_ready, input int bound);
        int k;
        k = 0;
        while (!Done && k < bound) begin
            if (rand_ready) OutReady = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        check("done_reached", 32'(Done), 32'd1);
        OutReady = 1'b1;
        done_exp++;
        tick();
        check("busy_after_done", 32'(Busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(done_exp));
    endtask

    task automatic wait_beat(input logic [A-1:0] addr, input int bound);
        int k;
        k = 0;
        while (!(OutValid && OutAddr == addr) && k < bound) begin
            tick();
            k++;
        end
        check("beat_reached", 32'(OutValid && OutAddr == addr), 32'd1);
    endtask

    // Monitor: compares each accepted beat, beat stability under backpressure and Done width.
    initial begin
        beat_t e;
        logic [W+A:0] held;
        logic hold_pend, prev_done;
        hold_pend = 1'b0;
        prev_done = 1'b0;
        held = '0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                hold_pend = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (Done) done_seen++;
                if (prev_done) check("done_one_cycle", 32'(Done), 32'd0);
                prev_done = Done;
                if (hold_pend && OutValid)
                    check("hold_stable", 32'({OutData, OutAddr, OutLast}), 32'(held));
                if (OutValid && OutReady && !Abort) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(OutAddr), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(OutData), 32'(e.d));
                        check("beat_addr", 32'(OutAddr), 32'(e.a));
                        check("beat_last", 32'(OutLast), 32'(e.l));
                    end
                end
                hold_pend = OutValid && !OutReady && !Abort;
                held = {OutData, OutAddr, OutLast};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int jdone;
        logic ev, ed;
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; OutReady = 1'b1;
        regs[0] = 8'd11; regs[1] = 8'd22; regs[2] = 8'd33; regs[3] = 8'd44;
        tick(); tick();
        check("rst_outdata", 32'(OutData), 32'd0);
        check("rst_outaddr", 32'(OutAddr), 32'd0);
        check("rst_raddr", 32'(RaddrOut), 32'd0);
        check("rst_valid_last", 32'({OutValid, OutLast}), 32'd0);
        check("rst_busy_done", 32'({Busy, Done}), 32'd0);
        Reset = 1'b0;
        tick();
        check("idle_busy", 32'(Busy), 32'd0);

        // Full sweep with cycle-exact latency.
        start_sweep(1'b0);
        jdone = 2 * int'(NR) + CKS;
        for (int j = 1; j <= jdone; j++) begin
            tick();
            ev = ((j < 2 * int'(NR)) && (j % 2 == 1)) || ((CKS != 0) && (j == 2 * int'(NR)));
            ed = (j == jdone);
            check("lat_valid", 32'(OutValid), 32'(ev));
            check("lat_done", 32'(Done), 32'(ed));
            check("lat_busy", 32'(Busy), 32'd1);
        end
        done_exp++;
        tick();
        check("full_busy_end", 32'(Busy), 32'd0);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);
        check("full_done_count", 32'(done_seen), 32'(done_exp));

        // Backpressure on beat 1.
        OutReady = 1'b1;
        start_sweep(1'b0);
        wait_beat(A'(1), 20);
        OutReady = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("bp_valid", 32'(OutValid), 32'd1);
            check("bp_data", 32'(OutData), 32'd22);
            check("bp_addr", 32'(OutAddr), 32'd1);
        end
        OutReady = 1'b1;
        wait_done(1'b0, 40);

        // Abort during beat 2.
        start_sweep(1'b0);
        wait_beat(A'(2), 20);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_valid", 32'(OutValid), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_left", 32'(exp_q.size()), 32'(int'(NR) - 2 + CKS));
        exp_q.delete();
        repeat (4) tick();
        check("abort_no_done", 32'(done_seen), 32'(done_exp));

        // Reset during FETCH of address 2, then a fresh sweep.
        start_sweep(1'b0);
        begin
            int k;
            k = 0;
            while (!(Busy && !OutValid && RaddrOut == A'(2)) && k < 20) begin
                tick();
                k++;
            end
            check("fetch2_reached", 32'(RaddrOut), 32'd2);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst_data_addr", 32'({OutData, OutAddr, RaddrOut}), 32'd0);
        check("mrst_flags", 32'({OutValid, OutLast, Busy, Done}), 32'd0);
        check("mrst_left", 32'(exp_q.size()), 32'(int'(NR) - 2 + CKS));
        exp_q.delete();
        start_sweep(1'b0);
        wait_done(1'b0, 40);

        // Checksum pattern (plain sweep when the checksum is not built in).
        regs[0] = 8'h0F; regs[1] = 8'hF0; regs[2] = 8'h55; regs[3] = 8'hAA;
        start_sweep(1'b0);
        wait_done(1'b0, 40);

        // Start pulsed again while busy is ignored.
        start_sweep(1'b0);
        wait_beat(A'(1), 20);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(1'b0, 40);

        // Randomized contents and backpressure; Abort alongside Start in IDLE still starts.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < int'(NR); i++) regs[i] = W'($urandom);
            start_sweep(1'($urandom_range(0, 1)));
            check("rand_started", 32'(Busy), 32'd1);
            wait_done(1'b1, 200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_readback.md
REG_READBACK -- requirements
Module: reg_readback

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the register data width in bits.
REQ-002 The block SHALL have parameter A, default 2, meaning the register address width; 2**A registers are swept.
REQ-003 Port Clk SHALL be an input, 1 bit wide: the clock; all state updates on its rising edge.
REQ-004 Port Reset SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-005 Port Start SHALL be an input, 1 bit wide: requests a sweep of all registers; sampled only in IDLE.
REQ-006 Port Abort SHALL be an input, 1 bit wide: cancels an in-progress sweep.
REQ-007 Port RaddrOut SHALL be an output, A bits wide: the read address driven to the register file read port.
REQ-008 Port RdataIn SHALL be an input, W bits wide: the combinational read data returned for RaddrOut.
REQ-009 Port OutData SHALL be an output, W bits wide: the stream data beat.
REQ-010 Port OutAddr SHALL be an output, A bits wide: the register index of the current beat.
REQ-011 Port OutValid SHALL be an output, 1 bit wide: the beat is valid.
REQ-012 Port OutReady SHALL be an input, 1 bit wide: the sink accepts the beat.
REQ-013 Port OutLast SHALL be an output, 1 bit wide: marks the final beat of the sweep.
REQ-014 Port Busy SHALL be an output, 1 bit wide: high in every state except IDLE.
REQ-015 Port Done SHALL be an output, 1 bit wide: a one-cycle pulse when the sweep completes normally.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, SEND and FINISH, plus CKSUM when the macro is enabled.
REQ-017 IDLE with Start=1 SHALL go to FETCH, with the address counter cleared to 0 on the same edge.
REQ-018 IDLE with Start=0 SHALL remain in IDLE.
REQ-019 Start SHALL be ignored in every state except IDLE.
REQ-020 RaddrOut SHALL equal the address counter at all times.
REQ-021 On the edge leaving FETCH, the block SHALL capture RdataIn into OutData and the counter into OutAddr, then go to SEND.
REQ-022 OutValid SHALL be 1 only in SEND and in CKSUM.
REQ-023 OutData, OutAddr and OutLast SHALL hold stable while OutValid=1 and OutReady=0.
REQ-024 In SEND, a handshake (OutValid & OutReady) with counter < 2**A-1 SHALL increment the counter and go to FETCH.
REQ-025 In SEND, a handshake with counter == 2**A-1 SHALL go to FINISH, or to CKSUM when the macro is enabled.
REQ-026 The address counter SHALL never wrap during a sweep.
REQ-027 Latency: with Start=1 sampled at edge N and OutReady held at 1, beat k SHALL be valid in the cycle after edge N+1+2k.
REQ-028 The sweep SHALL therefore take 2*(2**A) beat cycles, with no back-to-back beats.
REQ-029 FINISH SHALL assert Done=1 for exactly one cycle, then go to IDLE.
REQ-030 Abort=1 in any state other than IDLE SHALL go to IDLE on the next edge, with OutValid=0 and no Done pulse.
REQ-031 Abort SHALL take priority over a simultaneous handshake.
REQ-032 Abort in IDLE SHALL have no effect.
REQ-033 Abort=1 together with Start=1 in IDLE SHALL start the sweep, since Abort is ignored in IDLE.
REQ-034 OutReady=1 outside SEND/CKSUM SHALL have no effect.

Reset
REQ-035 Reset SHALL take priority over Abort, Start and the handshake.
REQ-036 Reset SHALL force the state to IDLE and the address counter to 0.
REQ-037 Reset SHALL set OutData=0, OutAddr=0, OutValid=0, OutLast=0, Busy=0, Done=0 and the checksum register to 0.
REQ-038 Reset asserted mid-sweep SHALL discard the sweep with no Done pulse.

Configuration
REQ-039 Macro REG_READBACK_CHECKSUM_EN SHALL, when defined, clear a W-bit XOR accumulator on the IDLE-to-FETCH transition and XOR each captured RdataIn into it.
REQ-040 With REG_READBACK_CHECKSUM_EN defined, CKSUM SHALL present one extra beat: OutData = accumulator, OutAddr = 0, OutLast = 1.
REQ-041 With REG_READBACK_CHECKSUM_EN defined, the CKSUM handshake SHALL go to FINISH, and the register beats SHALL have OutLast = 0.
REQ-042 With REG_READBACK_CHECKSUM_EN undefined, the CKSUM state and the accumulator SHALL be absent, and OutLast SHALL be 1 on the beat for register 2**A-1.

Verification
REQ-043 The bench SHALL cover a full sweep: W=8, A=2, registers {11,22,33,44}, OutReady=1, pulse Start -> beats 11,22,33,44 at addresses 0..3, OutLast on address 3 (macro off), then one Done pulse.
REQ-044 The bench SHALL cover backpressure: OutReady=0 for 5 cycles on beat 1 -> OutValid held, OutData=22 and OutAddr=1 stable throughout, and beat 2 not issued until accepted.
REQ-045 The bench SHALL cover abort: Abort=1 during beat 2's SEND with OutReady=1 -> IDLE next cycle, no beat-2 acceptance, Done never asserted, Busy=0.
REQ-046 The bench SHALL cover reset mid-sweep: Reset=1 during FETCH of address 2 -> all outputs 0 next cycle, then a fresh Start sweeps again from address 0.
REQ-047 The bench SHALL cover the checksum (macro on): registers {0x0F,0xF0,0x55,0xAA} -> five beats, with the fifth beat OutData=0x00 and OutLast=1, then Done.
REQ-048 The bench SHALL cover a Start while busy: Start pulsed again mid-sweep -> ignored, exactly 4 register beats and a single Done.
